me_search_core: RTL and testbench
=================================

# me_search_core

Parametrised full-search motion-estimation core: the successor to the fixed 16-lane, 8x8, free-running SAD engine. It accepts one current-block row and one reference-window row per beat through a valid/ready stream. NCOL SAD lanes evaluate all horizontal candidates in parallel, and each search reports the minimum-SAD motion vector through a valid/ready result port. It sits between the window fetch/line-buffer stage and the MV write-back stage of the ME pipeline.

## Interface
- PIX_W, 8, pixel bit width (unsigned luma)
- BLK, 8, block edge in pixels; rows per candidate and pixels per row
- NCOL, 16, horizontal candidates = SAD lanes (power of two)
- NROW, 16, maximum vertical candidates per search
- SAD_W, derived, $clog2(BLK*BLK*(2^PIX_W-1)+1); 14 for the defaults
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- search_rows  in  $clog2(NROW+1)  vertical candidate count; sampled on the first beat of a search; 0 or >NROW means NROW
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- crt_row  in  BLK*PIX_W  current-block row r; pixel c at bits [c*PIX_W +: PIX_W]
- pre_row  in  (NCOL+BLK-1)*PIX_W  reference-window row y+r; pixel k at [k*PIX_W +: PIX_W]
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- sad_min  out  SAD_W  minimum block SAD
- mv_x  out  $clog2(NCOL)  column index of the winning candidate
- mv_y  out  $clog2(NROW)  row index of the winning candidate

## Operation
- Beat order within a search: y = 0..R-1 (outer), r = 0..BLK-1 (inner), where R is the effective search_rows. A search is R*BLK beats.
- Lane x computes the row SAD of crt_row pixels 0..BLK-1 against pre_row pixels x..x+BLK-1 and adds it into acc[x].
- acc[x] is cleared (loaded, not added) on r = 0. It holds the block SAD for candidate (x, y) after the r = BLK-1 beat.
- Compare tree over the NCOL accumulators gives the minimum and its lane index. On ties the lower x wins.
- Running min updates only when tree_min < sad_run, using strict less-than. Ties therefore keep the earliest y, giving overall priority to lowest y, then lowest x.
- sad_run is set to all-ones and mv to 0 at the start of each search.
- Internal counters: r_cnt (0..BLK-1) and y_cnt (0..R-1), advancing only on accepted beats and wrapping to 0 after the last beat.
- FSM states:
  - RUN: in_ready = 1. The last beat (y_cnt = R-1, r_cnt = BLK-1) moves to FLUSH.
  - FLUSH: 1 cycle, in_ready = 0. The final compare commits.
  - OUT: in_ready = 0, out_valid = 1. Outputs are held stable until out_ready, then the FSM returns to RUN.
- Idle cycles (in_valid = 0) inside RUN change no state.
- Outputs sad_min/mv_x/mv_y are registered and change only on entering OUT.
- Arithmetic: absolute differences are PIX_W bits, row sums are $clog2(BLK*(2^PIX_W-1)+1) bits, and accumulators are SAD_W bits. Overflow is impossible by construction.

## Timing
- Reset (rst high at a clock edge):
  - FSM → RUN, counters → 0, acc → 0, sad_run → all-ones.
  - Outputs: out_valid = 0, sad_min = all-ones, mv_x = 0, mv_y = 0.
  - in_ready = 1 from the first cycle after reset is released.
- Reset mid-search or mid-OUT discards the partial or pending result. No out_valid is produced for that search.
- Latency: last beat accepted at edge T; FLUSH during cycle T+1; out_valid high from T+2.
- With out_ready = 1 at T+2, in_ready is high again at T+3. Minimum search period is R*BLK + 2 cycles.
- Candidate commit: accumulators complete at edge t (r = BLK-1 beat). The running min updates at edge t+1 regardless of in_valid on the next cycle.
- Backpressure: while in OUT with out_ready = 0, in_ready stays 0 and outputs are frozen indefinitely.
- search_rows changes outside the first beat are ignored.
- R = 1 is legal: a search is BLK beats.

## Test plan
- Identical frames, with pre_row a shifted copy so that only candidate (x=5, y=3) matches exactly, R = 16 → sad_min = 0, mv_x = 5, mv_y = 3, out_valid 2 cycles after beat 128.
- All pixels equal (all SADs 0) → mv_x = 0, mv_y = 0, which checks tie-breaking. Then crt all 255, pre all 0 → sad_min = 16320, mv = (0,0).
- Random stimulus, R = 16, in_valid randomly toggled at 50% → result matches the reference-model minimum under lowest-y-then-x priority. Counters do not advance on idle cycles.
- out_ready held low for 20 cycles after out_valid → in_ready stays 0, outputs stable. The next search started after the handshake produces an independent correct result.
- search_rows = 1, then 0 (treated as 16) → first result after 8 beats with mv_y = 0; second result after 128 beats.
- rst asserted at beat 60 of a search → next cycle out_valid = 0, sad_min = 16383, mv = 0. A fresh full search then yields the correct result.

Source files
------------

// File: rtl/me_search_core_if.sv
// rtl/me_search_core_if.sv - beat input stream and MV result port of the motion-estimation core
interface me_search_core_if #(
  parameter int PIX_W = 8,
  parameter int BLK   = 8,
  parameter int NCOL  = 16,
  parameter int NROW  = 16
) ();
  localparam int SAD_W = $clog2(BLK * BLK * (2 ** PIX_W - 1) + 1);

  logic [$clog2(NROW+1)-1:0]     search_rows;
  logic                          in_valid;
  logic                          in_ready;
  logic [BLK*PIX_W-1:0]          crt_row;
  logic [(NCOL+BLK-1)*PIX_W-1:0] pre_row;
  logic                          out_valid;
  logic                          out_ready;
  logic [SAD_W-1:0]              sad_min;
  logic [$clog2(NCOL)-1:0]       mv_x;
  logic [$clog2(NROW)-1:0]       mv_y;

  modport master (
    output search_rows, in_valid, crt_row, pre_row, out_ready,
    input  in_ready, out_valid, sad_min, mv_x, mv_y
  );

  modport slave (
    input  search_rows, in_valid, crt_row, pre_row, out_ready,
    output in_ready, out_valid, sad_min, mv_x, mv_y
  );
endinterface

// File: rtl/me_search_core.sv
// rtl/me_search_core.sv - full-search SAD engine, NCOL parallel lanes, min-SAD motion vector per search
module me_search_core #(
  parameter int PIX_W = 8,
  parameter int BLK   = 8,
  parameter int NCOL  = 16,
  parameter int NROW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  me_search_core_if.slave  bus
);
  localparam int ROW_W = $clog2(BLK * (2 ** PIX_W - 1) + 1);
  localparam int SAD_W = $clog2(BLK * BLK * (2 ** PIX_W - 1) + 1);
  localparam int XW    = $clog2(NCOL);
  localparam int YW    = $clog2(NROW);
  localparam int RW    = $clog2(BLK);
  localparam int NW    = $clog2(NROW + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  logic [1:0]       state;
  logic [RW-1:0]    r_cnt;
  logic [YW-1:0]    y_cnt;
  logic [NW-1:0]    rows_q;
  logic [SAD_W-1:0] acc [NCOL];
  logic [ROW_W-1:0] row_sad [NCOL];
  logic [SAD_W-1:0] sad_run;
  logic [XW-1:0]    run_x;
  logic [YW-1:0]    run_y;
  logic             commit;
  logic [YW-1:0]    commit_y;
  logic [SAD_W-1:0] sad_min_q;
  logic [XW-1:0]    mv_x_q;
  logic [YW-1:0]    mv_y_q;

  logic [SAD_W-1:0] tree_min;
  logic [XW-1:0]    tree_idx;
  logic             beat_ok;
  logic             first_beat;
  logic             last_r;
  logic             last_y;
  logic             better;
  logic [NW-1:0]    rows_in;
  logic [NW-1:0]    rows_cur;

  assign beat_ok    = bus.in_valid && (state == ST_RUN);
  assign first_beat = (y_cnt == '0) && (r_cnt == '0);
  assign rows_in    = ((bus.search_rows == '0) || (bus.search_rows > NW'(NROW)))
                      ? NW'(NROW) : bus.search_rows;
  // search_rows only matters on the first beat; later beats use the latched count
  assign rows_cur   = first_beat ? rows_in : rows_q;
  assign last_r     = (r_cnt == RW'(BLK - 1));
  assign last_y     = (NW'(y_cnt) == rows_cur - NW'(1));
  assign better     = commit && (tree_min < sad_run);

  for (genvar x = 0; x < NCOL; x++) begin : g_lane
    always_comb begin
      logic [ROW_W-1:0] s;
      logic [PIX_W-1:0] a;
      logic [PIX_W-1:0] b;
      s = '0;
      a = '0;
      b = '0;
      for (int c = 0; c < BLK; c++) begin
        a = bus.crt_row[c*PIX_W +: PIX_W];
        b = bus.pre_row[(x+c)*PIX_W +: PIX_W];
        s = s + ROW_W'((a > b) ? (a - b) : (b - a));
      end
      row_sad[x] = s;
    end
  end

  // Heap-ordered binary tree: left subtrees hold lower lanes, so ties keep the lower x
  always_comb begin
    logic [SAD_W-1:0] tv [2*NCOL-1];
    logic [XW-1:0]    ti [2*NCOL-1];
    for (int i = 0; i < NCOL; i++) begin
      tv[NCOL-1+i] = acc[i];
      ti[NCOL-1+i] = XW'(i);
    end
    for (int i = NCOL - 2; i >= 0; i--) begin
      if (tv[2*i+2] < tv[2*i+1]) begin
        tv[i] = tv[2*i+2];
        ti[i] = ti[2*i+2];
      end else begin
        tv[i] = tv[2*i+1];
        ti[i] = ti[2*i+1];
      end
    end
    tree_min = tv[0];
    tree_idx = ti[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      r_cnt     <= '0;
      y_cnt     <= '0;
      rows_q    <= NW'(NROW);
      for (int x = 0; x < NCOL; x++) acc[x] <= '0;
      sad_run   <= '1;
      run_x     <= '0;
      run_y     <= '0;
      commit    <= 1'b0;
      commit_y  <= '0;
      sad_min_q <= '1;
      mv_x_q    <= '0;
      mv_y_q    <= '0;
    end else begin
      commit <= 1'b0;
      // a candidate row commits the cycle after its accumulators complete
      if (better) begin
        sad_run <= tree_min;
        run_x   <= tree_idx;
        run_y   <= commit_y;
      end
      case (state)
        ST_RUN: begin
          if (beat_ok) begin
            for (int x = 0; x < NCOL; x++) begin
              acc[x] <= (r_cnt == '0) ? SAD_W'(row_sad[x])
                                      : acc[x] + SAD_W'(row_sad[x]);
            end
            commit   <= last_r;
            commit_y <= y_cnt;
            if (first_beat) rows_q <= rows_in;
            if (last_r) begin
              r_cnt <= '0;
              if (last_y) begin
                y_cnt <= '0;
                state <= ST_FLUSH;
              end else begin
                y_cnt <= y_cnt + YW'(1);
              end
            end else begin
              r_cnt <= r_cnt + RW'(1);
            end
          end
        end
        ST_FLUSH: begin
          state     <= ST_OUT;
          sad_min_q <= better ? tree_min : sad_run;
          mv_x_q    <= better ? tree_idx : run_x;
          mv_y_q    <= better ? commit_y : run_y;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            state   <= ST_RUN;
            sad_run <= '1;
            run_x   <= '0;
            run_y   <= '0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_RUN);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.sad_min   = sad_min_q;
  assign bus.mv_x      = mv_x_q;
  assign bus.mv_y      = mv_y_q;
endmodule

// File: tb/tb_me_search_core.sv
// tb/tb_me_search_core.sv - randomized bench for me_search_core against an exhaustive SAD reference model
module tb_me_search_core;
  localparam int PIX_W = 8;
  localparam int BLK   = 8;
  localparam int NCOL  = 16;
  localparam int NROW  = 16;
  localparam int WR    = NROW + BLK - 1;
  localparam int WC    = NCOL + BLK - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  me_search_core_if #(.PIX_W(PIX_W), .BLK(BLK), .NCOL(NCOL), .NROW(NROW)) bus ();
  me_search_core #(.PIX_W(PIX_W), .BLK(BLK), .NCOL(NCOL), .NROW(NROW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int crt [BLK][BLK];
  int win [WR][WC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [BLK*PIX_W-1:0] pack_crt(input int r);
    logic [BLK*PIX_W-1:0] v;
    v = '0;
    for (int c = 0; c < BLK; c++) v[c*PIX_W +: PIX_W] = PIX_W'(crt[r][c]);
    return v;
  endfunction

  function automatic logic [WC*PIX_W-1:0] pack_pre(input int row);
    logic [WC*PIX_W-1:0] v;
    v = '0;
    for (int k = 0; k < WC; k++) v[k*PIX_W +: PIX_W] = PIX_W'(win[row][k]);
    return v;
  endfunction

  // 0 random, 1 flat frame, 2 crt white / ref black, 3 block copied from window at (5,3)
  task automatic fill(input int mode);
    int f;
    f = $urandom_range(255);
    for (int i = 0; i < WR; i++)
      for (int k = 0; k < WC; k++)
        win[i][k] = (mode == 0 || mode == 3) ? $urandom_range(255) : (mode == 1) ? f : 0;
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        crt[r][c] = (mode == 0) ? $urandom_range(255) : (mode == 1) ? f :
                    (mode == 2) ? 255 : win[3+r][5+c];
  endtask

  task automatic model(input int rows, output int best, output int bx, output int by);
    int s;
    best = 32'h7fffffff;
    bx = 0;
    by = 0;
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < NCOL; x++) begin
        s = 0;
        for (int r = 0; r < BLK; r++)
          for (int c = 0; c < BLK; c++)
            s += (crt[r][c] > win[y+r][x+c]) ? crt[r][c] - win[y+r][x+c]
                                             : win[y+r][x+c] - crt[r][c];
        if (s < best) begin
          best = s;
          bx = x;
          by = y;
        end
      end
  endtask

  task automatic drive_beats(input int total, input int sr, input int idle_pct, output int done);
    int  cyc;
    logic v;
    logic rdy;
    done = 0;
    cyc  = 0;
    while (done < total && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      v = ($urandom_range(99) >= idle_pct);
      bus.in_valid    = v;
      bus.crt_row     = pack_crt(done % BLK);
      bus.pre_row     = pack_pre(done / BLK + done % BLK);
      bus.search_rows = (done == 0) ? 5'(sr) : 5'($urandom_range(31));
      rdy = bus.in_ready;
      @(posedge clk);
      if (v && rdy) done++;
    end
  endtask

  task automatic run_search(input int mode, input int sr, input int idle_pct, input int hold,
                            input string name);
    int rows, done, cyc, ex_sad, ex_x, ex_y;
    logic stable;
    logic [31:0] snap_sad, snap_x, snap_y;
    fill(mode);
    rows = (sr == 0 || sr > NROW) ? NROW : sr;
    model(rows, ex_sad, ex_x, ex_y);
    drive_beats(rows * BLK, sr, idle_pct, done);
    check({name, "_beats"}, done, rows * BLK);
    cyc = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      cyc++;
    end while (bus.out_valid !== 1'b1 && cyc < 10);
    check({name, "_latency"}, cyc, 2);
    check({name, "_sad"}, 32'(bus.sad_min), ex_sad);
    check({name, "_mv_x"}, 32'(bus.mv_x), ex_x);
    check({name, "_mv_y"}, 32'(bus.mv_y), ex_y);
    snap_sad = 32'(bus.sad_min);
    snap_x   = 32'(bus.mv_x);
    snap_y   = 32'(bus.mv_y);
    stable   = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || 32'(bus.sad_min) !== snap_sad ||
          32'(bus.mv_x) !== snap_x || 32'(bus.mv_y) !== snap_y)
        stable = 1'b0;
    end
    if (hold > 0) check({name, "_hold_stable"}, stable, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, "_valid_drop"}, bus.out_valid, 0);
    check({name, "_ready_back"}, bus.in_ready, 1);
  endtask

  task automatic reset_mid(input int beats);
    int done;
    fill(0);
    drive_beats(beats, NROW, 0, done);
    check("rst_mid_beats", done, beats);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_sad", 32'(bus.sad_min), 16383);
    check("rst_mid_mv_x", 32'(bus.mv_x), 0);
    check("rst_mid_mv_y", 32'(bus.mv_y), 0);
    check("rst_mid_ready", bus.in_ready, 1);
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.crt_row     = '0;
    bus.pre_row     = '0;
    bus.search_rows = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_valid", bus.out_valid, 0);
    check("reset_sad", 32'(bus.sad_min), 16383);
    check("reset_mv_x", 32'(bus.mv_x), 0);
    check("reset_mv_y", 32'(bus.mv_y), 0);
    check("reset_ready", bus.in_ready, 1);

    run_search(3, 16, 0, 0, "match");
    run_search(1, 16, 0, 0, "flat");
    run_search(2, 16, 0, 0, "max");
    run_search(0, 16, 50, 20, "rand_hold");
    for (int i = 0; i < 3; i++) run_search(0, 16, 50, 0, "rand");
    run_search(0, 1, 30, 0, "rows1");
    run_search(0, 0, 30, 0, "rows0");
    run_search(0, 5, 30, 0, "rows5");
    run_search(0, 20, 30, 0, "rows20");
    reset_mid(60);
    run_search(0, 16, 50, 0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
